// File: rtl/sram_pkg.sv
// Shared types and limits for the SRAM pin-level responder.
package sram_pkg;

    localparam int READ_LAT_MAX = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ_WAIT,
        S_READ_DRIVE
    } resp_state_t;

endpackage

// File: rtl/sram_resp_array.sv
// Single-port storage: synchronous write, registered read.
// The read register doubles as the responder's dq output, so only it is reset.
module sram_resp_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_responder.sv
// Memory-side endpoint for the async-SRAM pin interface: decodes ce/oe/we,
// returns reads after READ_LAT cycles on a split dq bus, flags protocol abuse.
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sram_ce_n,
    input  logic              sram_oe_n,
    input  logic              sram_we_n,
    input  logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dq_in,
    output logic [DATA_W-1:0] sram_dq_out,
    output logic              sram_dq_oe,
    output logic              illegal_err,
    output logic              contention_err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int CW = $clog2(READ_LAT_MAX);

    generate
        if ((READ_LAT < 1) || (READ_LAT > READ_LAT_MAX)) begin : g_bad_lat
            $error("sram_responder: READ_LAT must be 1..4");
        end
    endgenerate

    resp_state_t       state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, rd_addr, mem_addr;
    logic [DATA_W-1:0] wr_data;
    logic [CW-1:0]     cnt;
    logic              wr_req, rd_req;
    logic              mem_we, mem_re, wr_latch, rd_latch, cnt_load;
    logic              oe_set, oe_clr, rd_inc, wr_inc, illegal_set, contention_set;

    assign wr_req = !sram_ce_n && !sram_we_n;
    assign rd_req = !sram_ce_n && !sram_oe_n && sram_we_n;

    always_comb begin
        state_nxt      = state;
        mem_addr       = rd_addr;
        mem_we         = 1'b0;
        mem_re         = 1'b0;
        wr_latch       = 1'b0;
        rd_latch       = 1'b0;
        cnt_load       = 1'b0;
        oe_set         = 1'b0;
        oe_clr         = 1'b0;
        rd_inc         = 1'b0;
        wr_inc         = 1'b0;
        illegal_set    = 1'b0;
        contention_set = 1'b0;
        case (state)
            S_IDLE: begin
                // Single-latency reads fetch straight off the pins this edge.
                mem_addr = sram_addr;
                if (wr_req && !sram_oe_n) begin
                    illegal_set = 1'b1;
                end else if (wr_req) begin
                    wr_latch  = 1'b1;
                    state_nxt = S_WRITE;
                end else if (rd_req) begin
                    rd_latch = 1'b1;
                    cnt_load = 1'b1;
                    if (READ_LAT == 1) begin
                        mem_re    = 1'b1;
                        oe_set    = 1'b1;
                        state_nxt = S_READ_DRIVE;
                    end else begin
                        state_nxt = S_READ_WAIT;
                    end
                end
            end
            S_WRITE: begin
                mem_addr = wr_addr;
                if (wr_req) begin
                    wr_latch = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    wr_inc    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_READ_WAIT: begin
                // Fetch on the edge where the count would reach zero.
                if (cnt == CW'(1)) begin
                    mem_re    = 1'b1;
                    oe_set    = 1'b1;
                    state_nxt = S_READ_DRIVE;
                end
                contention_set = wr_req && sram_dq_oe;
            end
            S_READ_DRIVE: begin
                oe_clr         = 1'b1;
                rd_inc         = 1'b1;
                state_nxt      = S_IDLE;
                contention_set = wr_req && sram_dq_oe;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            wr_addr        <= '0;
            wr_data        <= '0;
            rd_addr        <= '0;
            sram_dq_oe     <= 1'b0;
            illegal_err    <= 1'b0;
            contention_err <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
        end else begin
            state <= state_nxt;
            if (cnt_load)
                cnt <= CW'(READ_LAT - 1);
            else if (state == S_READ_WAIT)
                cnt <= cnt - CW'(1);
            if (wr_latch) begin
                wr_addr <= sram_addr;
                wr_data <= sram_dq_in;
            end
            if (rd_latch)
                rd_addr <= sram_addr;
            if (oe_set)
                sram_dq_oe <= 1'b1;
            else if (oe_clr)
                sram_dq_oe <= 1'b0;
            if (illegal_set)
                illegal_err <= 1'b1;
            if (contention_set)
                contention_err <= 1'b1;
            if (rd_inc && (rd_count != '1))
                rd_count <= rd_count + CNT_W'(1);
            if (wr_inc && (wr_count != '1))
                wr_count <= wr_count + CNT_W'(1);
        end
    end

    sram_resp_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (mem_we),
        .re   (mem_re),
        .addr (mem_addr),
        .wdata(wr_data),
        .rdata(sram_dq_out)
    );

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench: three responders at READ_LAT 1/2/3 share one stimulus bus;
// only the selected instance sees ce_n low.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
    logic [7:0]  addr = '0;
    logic [15:0] din = '0;
    int          sel = 0;
    int          checks = 0;
    int          errors = 0;

    logic [2:0]  ce_v;
    logic [15:0] dq_o   [3];
    logic        oe_o   [3];
    logic        ill_o  [3];
    logic        con_o  [3];
    logic [15:0] rdc_o  [3];
    logic [15:0] wrc_o  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign ce_v[g] = (sel == g) ? ce_n : 1'b1;
        sram_responder #(.ADDR_W(8), .DATA_W(16), .READ_LAT(g + 1), .CNT_W(16)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .sram_ce_n     (ce_v[g]),
            .sram_oe_n     (oe_n),
            .sram_we_n     (we_n),
            .sram_addr     (addr),
            .sram_dq_in    (din),
            .sram_dq_out   (dq_o[g]),
            .sram_dq_oe    (oe_o[g]),
            .illegal_err   (ill_o[g]),
            .contention_err(con_o[g]),
            .rd_count      (rdc_o[g]),
            .wr_count      (wrc_o[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    endtask

    task automatic wr(input int idx, input logic [7:0] a, input logic [15:0] d);
        sel = idx; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a; din = d;
        cyc();
        idle();
        cyc();
    endtask

    // oe must be high only in the READ_LAT-th cycle after the sampling edge.
    task automatic rd(input int idx, input logic [7:0] a, input logic [15:0] exp);
        int lat;
        lat = idx + 1;
        sel = idx; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = a;
        cyc();
        idle();
        for (int k = 1; k <= lat + 1; k++) begin
            chk($sformatf("dq_oe_l%0d_c%0d", lat, k), {31'd0, oe_o[idx]}, {31'd0, (k == lat)});
            if (k == lat)
                chk($sformatf("dq_out_l%0d_%0h", lat, a), {16'd0, dq_o[idx]}, {16'd0, exp});
            cyc();
        end
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_dq_out", {16'd0, dq_o[0]}, 32'h0);
        chk("rst_dq_oe", {31'd0, oe_o[0]}, 32'h0);
        chk("rst_illegal", {31'd0, ill_o[0]}, 32'h0);
        chk("rst_contention", {31'd0, con_o[0]}, 32'h0);
        chk("rst_rd_count", {16'd0, rdc_o[0]}, 32'h0);
        chk("rst_wr_count", {16'd0, wrc_o[0]}, 32'h0);
        rst_n = 1'b1;
        cyc();

        // single write then read, latency 1
        wr(0, 8'h12, 16'hBEEF);
        chk("wr_count_1", {16'd0, wrc_o[0]}, 32'd1);
        rd(0, 8'h12, 16'hBEEF);
        chk("rd_count_1", {16'd0, rdc_o[0]}, 32'd1);

        // latency 3 read of a preloaded word
        wr(2, 8'h05, 16'h1234);
        rd(2, 8'h05, 16'h1234);
        chk("rd_count_l3", {16'd0, rdc_o[2]}, 32'd1);

        // held write re-latches; last data wins, one commit
        sel = 0; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 8'h40;
        din = 16'h1111; cyc();
        din = 16'h2222; cyc();
        din = 16'h3333; cyc();
        idle(); cyc();
        chk("wr_count_relatch", {16'd0, wrc_o[0]}, 32'd2);
        rd(0, 8'h40, 16'h3333);
        chk("rd_count_2", {16'd0, rdc_o[0]}, 32'd2);

        // illegal ce/oe/we all low
        sel = 0; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0; addr = 8'h12; din = 16'h0;
        cyc();
        idle();
        chk("illegal_set", {31'd0, ill_o[0]}, 32'd1);
        chk("illegal_no_oe", {31'd0, oe_o[0]}, 32'd0);
        cyc();
        cyc();
        chk("illegal_sticky", {31'd0, ill_o[0]}, 32'd1);
        chk("illegal_rd_count", {16'd0, rdc_o[0]}, 32'd2);
        chk("illegal_wr_count", {16'd0, wrc_o[0]}, 32'd2);
        rd(0, 8'h12, 16'hBEEF);

        // write during the latency-2 drive cycle
        wr(1, 8'h12, 16'hCAFE);
        sel = 1; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1; addr = 8'h12;
        cyc();
        idle();
        chk("cont_wait_oe", {31'd0, oe_o[1]}, 32'd0);
        cyc();
        chk("cont_drive_oe", {31'd0, oe_o[1]}, 32'd1);
        chk("cont_drive_dq", {16'd0, dq_o[1]}, 32'hCAFE);
        ce_n = 1'b0; we_n = 1'b0; din = 16'h0000;
        cyc();
        idle();
        chk("contention_set", {31'd0, con_o[1]}, 32'd1);
        chk("cont_rd_count", {16'd0, rdc_o[1]}, 32'd1);
        chk("cont_wr_count", {16'd0, wrc_o[1]}, 32'd1);
        cyc();
        rd(1, 8'h12, 16'hCAFE);
        chk("contention_sticky", {31'd0, con_o[1]}, 32'd1);

        // reset while a write is pending
        wr(0, 8'h07, 16'hAAAA);
        sel = 0; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 8'h07; din = 16'h5555;
        cyc();
        rst_n = 1'b0;
        #1;
        idle();
        chk("rstw_dq_out", {16'd0, dq_o[0]}, 32'h0);
        chk("rstw_dq_oe", {31'd0, oe_o[0]}, 32'h0);
        chk("rstw_illegal", {31'd0, ill_o[0]}, 32'h0);
        chk("rstw_wr_count", {16'd0, wrc_o[0]}, 32'h0);
        chk("rstw_rd_count", {16'd0, rdc_o[0]}, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rstw_no_commit", {16'd0, wrc_o[0]}, 32'h0);
        rd(0, 8'h07, 16'hAAAA);
        chk("rstw_rd_count_after", {16'd0, rdc_o[0]}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable, cycle-based responder model for the asynchronous-SRAM-style pin interface driven by the team's SRAM controller FSM.
- Decodes active-low ce_n/oe_n/we_n, stores writes in an internal array, and returns read data on a split tri-state bus (dq_out plus dq_oe) after a programmable latency.
- Flags protocol violations and counts accesses. Used as the memory-side endpoint in controller benches and FPGA loopback builds.

Parameters:
- ADDR_W, 8, address width; the array has 2**ADDR_W words.
- DATA_W, 16, data width.
- READ_LAT, 1, cycles from the read-sampling edge to data driven. Legal range 1..4; other values are an elaboration error.
- CNT_W, 16, width of the access counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sram_ce_n  in  1  chip enable, active-low.
- sram_oe_n  in  1  output enable, active-low.
- sram_we_n  in  1  write enable, active-low.
- sram_addr  in  ADDR_W  address from controller.
- sram_dq_in  in  DATA_W  write data driven by controller.
- sram_dq_out  out  DATA_W  read data from responder.
- sram_dq_oe  out  1  responder drives dq while high.
- illegal_err  out  1  sticky: ce_n=0 with oe_n=0 and we_n=0 sampled together.
- contention_err  out  1  sticky: controller asserted we_n=0 while sram_dq_oe=1.
- rd_count  out  CNT_W  completed reads, saturating.
- wr_count  out  CNT_W  committed writes, saturating.

Behaviour:
- Clock and inputs: all inputs are sampled on posedge clk. All outputs are registered.
- Reset values: sram_dq_out=0, sram_dq_oe=0, illegal_err=0, contention_err=0, rd_count=0, wr_count=0, state=S_IDLE, latency counter=0.
- The memory array is not reset. Reading an unwritten location returns an undefined value.
- State S_IDLE (priority top to bottom):
  - ce_n=0, oe_n=0, we_n=0: set illegal_err; no access; stay in S_IDLE.
  - ce_n=0, we_n=0, oe_n=1: latch addr and dq_in into wr_addr/wr_data; go to S_WRITE.
  - ce_n=0, oe_n=0, we_n=1: latch addr into rd_addr; load counter with READ_LAT-1; go to S_READ_WAIT, or directly to S_READ_DRIVE if READ_LAT=1.
  - Otherwise stay in S_IDLE.
- State S_WRITE:
  - While ce_n=0 and we_n=0: re-latch wr_addr/wr_data each cycle; the last sampled value wins.
  - On the first edge where we_n=1 or ce_n=1 is sampled: commit mem[wr_addr]=wr_data, increment wr_count, go to S_IDLE.
  - A read is never started on the commit edge. A read still requested on the following edge starts normally and sees the new data.
- State S_READ_WAIT:
  - Decrement the counter each cycle.
  - At 0: load sram_dq_out=mem[rd_addr], set sram_dq_oe=1, go to S_READ_DRIVE.
  - Deasserting oe_n or ce_n during the wait does not cancel the read.
- State S_READ_DRIVE:
  - sram_dq_oe=1 for exactly one cycle, the READ_LAT-th cycle after the sampling edge.
  - On the next edge: clear sram_dq_oe, increment rd_count, go to S_IDLE. sram_dq_out holds its value.
- Contention: in S_READ_WAIT or S_READ_DRIVE, sampling ce_n=0 and we_n=0 while sram_dq_oe=1 sets contention_err. The write is ignored and the read completes.
- Counters saturate at all-ones and never wrap.
- Error flags are sticky until reset.
- Reset mid-operation returns to S_IDLE immediately. A pending write is dropped and the memory location is unchanged. sram_dq_oe drops asynchronously.
- Back-to-back reads: the minimum spacing is READ_LAT+1 cycles per read, because the responder must return to S_IDLE before it samples again.

Decomposition:
- Package sram_pkg:
  - resp_state_t enum {S_IDLE, S_WRITE, S_READ_WAIT, S_READ_DRIVE}, 2 bits.
  - Constant READ_LAT_MAX=4.
- One natural sub-module, sram_resp_array: a single-port synchronous-write, synchronous-read array of 2**ADDR_W x DATA_W. The FSM, counters and error logic stay in the top.

Test Plan:
- Single write, then read:
  - Stimulus: write addr 0x12 data 0xBEEF (ce_n=0, we_n=0 for 1 cycle), then read 0x12.
  - Response: wr_count=1; sram_dq_oe high exactly 1 cycle after the read-sampling edge with dq_out=0xBEEF; rd_count=1.
- Read latency:
  - Stimulus: READ_LAT=3, read a preloaded addr 0x05=0x1234.
  - Response: sram_dq_oe rises on the 3rd cycle after the sampling edge, stays high 1 cycle, dq_out=0x1234.
- Write re-latch:
  - Stimulus: hold we_n=0 for 3 cycles with data 0x1111, 0x2222, 0x3333 at addr 0x40.
  - Response: a later read of 0x40 returns 0x3333; wr_count increments by 1 only.
- Illegal access:
  - Stimulus: ce_n=0, oe_n=0, we_n=0 for 1 cycle.
  - Response: illegal_err=1 and stays 1; both counts unchanged; sram_dq_oe stays 0.
- Contention:
  - Stimulus: READ_LAT=2 read, then we_n=0 in the drive cycle with addr 0x12 data 0x0000.
  - Response: contention_err=1; a re-read of 0x12 still returns its prior value.
- Reset mid-write:
  - Stimulus: assert rst_n low while in S_WRITE at addr 0x07 (prior value 0xAAAA) with data 0x5555.
  - Response: all outputs return to reset values; a subsequent read of 0x07 returns 0xAAAA.
